// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard-control unit.
// Optional feature macro: HAZARD_PERF_CNT_EN (performance counters).
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } hazard_state_e;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side bundle between the 5-stage core and hazard_ctrl_unit.
// Counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic                  id_use_rs1, id_use_rs2;
    logic                  ex_memread, ex_is_mc, ex_branch_taken;
    logic                  mem_regwrite, wb_regwrite;

    logic                  pc_write, if_id_stall, if_id_flush;
    logic                  id_ex_stall, id_ex_flush, ex_mem_flush;
    logic [1:0]            fwd_a, fwd_b;
    logic                  mc_done;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0]      stall_cnt, flush_cnt, mc_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
               ex_memread, ex_is_mc, ex_branch_taken, mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        input  pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush,
               fwd_a, fwd_b, mc_done, stall_cnt, flush_cnt, mc_cnt
    );
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
               ex_memread, ex_is_mc, ex_branch_taken, mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        output pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush,
               fwd_a, fwd_b, mc_done, stall_cnt, flush_cnt, mc_cnt
    );
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
               ex_memread, ex_is_mc, ex_branch_taken, mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        input  pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush,
               fwd_a, fwd_b, mc_done
    );
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
               ex_memread, ex_is_mc, ex_branch_taken, mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        output pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush,
               fwd_a, fwd_b, mc_done
    );
`endif

endinterface

// File: rtl/hazard_mc_timer.sv
// Load/decrement latency counter with a zero flag for multi-cycle EX ops.
module hazard_mc_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Central stall/flush/forwarding control for the 5-stage core, with mul/div sequencing.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush/mc-start counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MC_LAT     = 4,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_ctrl_unit_if.slave   hif
);

    localparam int         LEFT_W   = $clog2(MC_LAT) + 1;
    localparam bit         MC_MULTI = (MC_LAT > 1);
    localparam logic [LEFT_W-1:0] MC_LOAD = MC_MULTI ? LEFT_W'(MC_LAT - 2) : '0;
    localparam logic [0:0] S_RUN     = 1'(RUN);
    localparam logic [0:0] S_MC_BUSY = 1'(MC_BUSY);

    logic [0:0]        state, state_nxt;
    logic [LEFT_W-1:0] mc_left;
    logic              mc_zero, mc_load, mc_dec, mc_start, load_use;
    logic              pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic              ex_mem_flush, mc_done;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic                  m_we,
        input logic [REG_ADDR_W-1:0] w_rd,
        input logic                  w_we
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if (m_we && (m_rd != '0) && (m_rd == src)) begin
            sel = FWD_MEM;
        end else if (w_we && (w_rd != '0) && (w_rd == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    assign hif.fwd_a = fwd_sel(hif.ex_rs1, hif.mem_rd, hif.mem_regwrite, hif.wb_rd, hif.wb_regwrite);
    assign hif.fwd_b = fwd_sel(hif.ex_rs2, hif.mem_rd, hif.mem_regwrite, hif.wb_rd, hif.wb_regwrite);

    assign load_use = hif.ex_memread && (hif.ex_rd != '0) &&
                      ((hif.id_use_rs1 && (hif.id_rs1 == hif.ex_rd)) ||
                       (hif.id_use_rs2 && (hif.id_rs2 == hif.ex_rd)));

    hazard_mc_timer #(.W(LEFT_W)) u_mc_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (mc_load),
        .load_val (MC_LOAD),
        .dec      (mc_dec),
        .cnt      (mc_left),
        .zero     (mc_zero)
    );

    always_comb begin
        state_nxt    = state;
        pc_write     = 1'b1;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mc_done      = 1'b0;
        mc_load      = 1'b0;
        mc_dec       = 1'b0;
        mc_start     = 1'b0;
        case (state)
            S_RUN: begin
                if (hif.ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (hif.ex_is_mc && MC_MULTI) begin
                    mc_start     = 1'b1;
                    pc_write     = 1'b0;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_flush = 1'b1;
                    mc_load      = 1'b1;
                    state_nxt    = S_MC_BUSY;
                end else begin
                    if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                    // Single-cycle "multi-cycle" op completes in place without holding the front end.
                    if (hif.ex_is_mc) begin
                        mc_start = 1'b1;
                        mc_done  = 1'b1;
                    end
                end
            end
            S_MC_BUSY: begin
                if (!mc_zero) begin
                    pc_write     = 1'b0;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_flush = 1'b1;
                    mc_dec       = 1'b1;
                end else begin
                    mc_done   = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    assign hif.pc_write     = pc_write;
    assign hif.if_id_stall  = if_id_stall;
    assign hif.if_id_flush  = if_id_flush;
    assign hif.id_ex_stall  = id_ex_stall;
    assign hif.id_ex_flush  = id_ex_flush;
    assign hif.ex_mem_flush = ex_mem_flush;
    assign hif.mc_done      = mc_done;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt, mc_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            mc_cnt    <= '0;
        end else begin
            stall_cnt <= sat_inc(stall_cnt, !pc_write);
            flush_cnt <= sat_inc(flush_cnt, if_id_flush);
            mc_cnt    <= sat_inc(mc_cnt, mc_start);
        end
    end

    assign hif.stall_cnt = stall_cnt;
    assign hif.flush_cnt = flush_cnt;
    assign hif.mc_cnt    = mc_cnt;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0) && mc_start;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: MC_LAT=4 main instance plus an MC_LAT=1 instance.
// With HAZARD_PERF_CNT_EN defined the counters are checked with CNT_W=2.
module tb_hazard_ctrl_unit;

    localparam int REG_ADDR_W = 5;
`ifdef HAZARD_PERF_CNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    typedef struct packed {
        logic       in_rst;
        logic       mc_start;
        logic       l1_pc_write;
        logic       l1_mc_done;
        logic       pc_write;
        logic       if_id_stall;
        logic       if_id_flush;
        logic       id_ex_stall;
        logic       id_ex_flush;
        logic       ex_mem_flush;
        logic [1:0] fwd_a;
        logic [1:0] fwd_b;
        logic       mc_done;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_unit_if #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) hif ();
    hazard_ctrl_unit_if #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) hif1 ();

    assign hif1.id_rs1          = hif.id_rs1;
    assign hif1.id_rs2          = hif.id_rs2;
    assign hif1.id_use_rs1      = hif.id_use_rs1;
    assign hif1.id_use_rs2      = hif.id_use_rs2;
    assign hif1.ex_rs1          = hif.ex_rs1;
    assign hif1.ex_rs2          = hif.ex_rs2;
    assign hif1.ex_rd           = hif.ex_rd;
    assign hif1.ex_memread      = hif.ex_memread;
    assign hif1.ex_is_mc        = hif.ex_is_mc;
    assign hif1.ex_branch_taken = hif.ex_branch_taken;
    assign hif1.mem_rd          = hif.mem_rd;
    assign hif1.mem_regwrite    = hif.mem_regwrite;
    assign hif1.wb_rd           = hif.wb_rd;
    assign hif1.wb_regwrite     = hif.wb_regwrite;

    hazard_ctrl_unit #(.REG_ADDR_W(REG_ADDR_W), .MC_LAT(4), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .hif (hif.slave)
    );

    hazard_ctrl_unit #(.REG_ADDR_W(REG_ADDR_W), .MC_LAT(1), .CNT_W(CNT_W)) u_dut_lat1 (
        .clk (clk),
        .rst (rst),
        .hif (hif1.slave)
    );

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic idle_inputs();
        hif.id_rs1 = '0;  hif.id_rs2 = '0;  hif.id_use_rs1 = 1'b0; hif.id_use_rs2 = 1'b0;
        hif.ex_rs1 = '0;  hif.ex_rs2 = '0;  hif.ex_rd = '0;
        hif.ex_memread = 1'b0; hif.ex_is_mc = 1'b0; hif.ex_branch_taken = 1'b0;
        hif.mem_rd = '0; hif.mem_regwrite = 1'b0; hif.wb_rd = '0; hif.wb_regwrite = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input exp_t e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    function automatic exp_t e_idle();
        exp_t e;
        e = '0;
        e.pc_write    = 1'b1;
        e.l1_pc_write = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_loaduse();
        exp_t e;
        e = e_idle();
        e.pc_write    = 1'b0;
        e.l1_pc_write = 1'b0;
        e.if_id_stall = 1'b1;
        e.id_ex_flush = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_flush();
        exp_t e;
        e = e_idle();
        e.if_id_flush = 1'b1;
        e.id_ex_flush = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_mcstall(input logic l1_done);
        exp_t e;
        e = e_idle();
        e.pc_write     = 1'b0;
        e.if_id_stall  = 1'b1;
        e.id_ex_stall  = 1'b1;
        e.ex_mem_flush = 1'b1;
        e.l1_mc_done   = l1_done;
        return e;
    endfunction

    // Monitor: one expectation is consumed per cycle, sampled on the falling edge.
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] m_stall = '0, m_flush = '0, m_mc = '0;

    function automatic logic [CNT_W-1:0] model_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction
`endif

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            string      nm;
            logic [10:0] act, req;
            logic [1:0]  act1, req1;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            act = {hif.pc_write, hif.if_id_stall, hif.if_id_flush, hif.id_ex_stall, hif.id_ex_flush,
                   hif.ex_mem_flush, hif.fwd_a, hif.fwd_b, hif.mc_done};
            req = {e.pc_write, e.if_id_stall, e.if_id_flush, e.id_ex_stall, e.id_ex_flush,
                   e.ex_mem_flush, e.fwd_a, e.fwd_b, e.mc_done};
            n_checks++;
            if (act !== req) begin
                n_fail++;
                $display("FAIL %s: pcw/ifs/iff/ids/idf/emf/fa/fb/done got %b expected %b", nm, act, req);
            end
            act1 = {hif1.pc_write, hif1.mc_done};
            req1 = {e.l1_pc_write, e.l1_mc_done};
            n_checks++;
            if (act1 !== req1) begin
                n_fail++;
                $display("FAIL %s lat1: pcw/done got %b expected %b", nm, act1, req1);
            end
`ifdef HAZARD_PERF_CNT_EN
            if (e.in_rst) begin
                m_stall = '0; m_flush = '0; m_mc = '0;
            end
            n_checks++;
            if ({hif.stall_cnt, hif.flush_cnt, hif.mc_cnt} !== {m_stall, m_flush, m_mc}) begin
                n_fail++;
                $display("FAIL %s perf: stall/flush/mc got %0d/%0d/%0d expected %0d/%0d/%0d", nm,
                         hif.stall_cnt, hif.flush_cnt, hif.mc_cnt, m_stall, m_flush, m_mc);
            end
            if (!e.in_rst) begin
                m_stall = model_inc(m_stall, !e.pc_write);
                m_flush = model_inc(m_flush, e.if_id_flush);
                m_mc    = model_inc(m_mc, e.mc_start);
            end
`endif
        end
    end

    initial begin
        exp_t e;
        rst = 1'b0;
        idle_inputs();

        // Reset state
        next_cycle();
        e = e_idle(); e.in_rst = 1'b1;
        push(e, "reset");
        next_cycle(); rst = 1'b1;
        push(e_idle(), "idle_after_reset");

        // Load-use on rs1, lasting one cycle
        next_cycle(); idle_inputs();
        hif.ex_memread = 1'b1; hif.ex_rd = 5'd5; hif.id_rs1 = 5'd5; hif.id_use_rs1 = 1'b1;
        push(e_loaduse(), "load_use_rs1");
        next_cycle(); idle_inputs();
        push(e_idle(), "load_use_released");

        next_cycle(); idle_inputs();
        hif.ex_memread = 1'b1; hif.ex_rd = 5'd5; hif.id_rs2 = 5'd5; hif.id_use_rs2 = 1'b0;
        push(e_idle(), "load_use_rs2_unused");
        next_cycle(); idle_inputs();
        hif.ex_memread = 1'b1; hif.ex_rd = 5'd0; hif.id_rs1 = 5'd0; hif.id_use_rs1 = 1'b1;
        push(e_idle(), "load_use_x0");
        next_cycle(); idle_inputs();
        hif.ex_memread = 1'b1; hif.ex_rd = 5'd12; hif.id_rs2 = 5'd12; hif.id_use_rs2 = 1'b1;
        push(e_loaduse(), "load_use_rs2");

        // Branch beats load-use
        next_cycle(); idle_inputs();
        hif.ex_memread = 1'b1; hif.ex_rd = 5'd5; hif.id_rs1 = 5'd5; hif.id_use_rs1 = 1'b1;
        hif.ex_branch_taken = 1'b1;
        push(e_flush(), "branch_and_load_use");

        // Forwarding
        next_cycle(); idle_inputs();
        hif.ex_rs1 = 5'd7; hif.ex_rs2 = 5'd3; hif.mem_rd = 5'd7; hif.wb_rd = 5'd7;
        hif.mem_regwrite = 1'b1; hif.wb_regwrite = 1'b1;
        e = e_idle(); e.fwd_a = 2'b10;
        push(e, "fwd_mem_priority");
        next_cycle(); hif.mem_rd = 5'd0;
        e = e_idle(); e.fwd_a = 2'b01;
        push(e, "fwd_wb");
        next_cycle(); hif.ex_rs1 = 5'd0; hif.wb_rd = 5'd0;
        push(e_idle(), "fwd_x0");
        next_cycle(); idle_inputs();
        hif.ex_rs2 = 5'd9; hif.mem_rd = 5'd9; hif.wb_rd = 5'd9; hif.wb_regwrite = 1'b1;
        e = e_idle(); e.fwd_b = 2'b01;
        push(e, "fwd_b_wb_mem_disabled");
        next_cycle(); hif.ex_rs1 = 5'd9; hif.mem_regwrite = 1'b1;
        e = e_idle(); e.fwd_a = 2'b10; e.fwd_b = 2'b10;
        push(e, "fwd_ab_mem");

        // Multi-cycle op, branch ignored while busy
        next_cycle(); idle_inputs(); hif.ex_is_mc = 1'b1;
        e = e_mcstall(1'b1); e.l1_pc_write = 1'b1; e.mc_start = 1'b1;
        push(e, "mc_start");
        next_cycle();
        e = e_mcstall(1'b1); e.l1_pc_write = 1'b1;
        push(e, "mc_busy1");
        next_cycle(); hif.ex_branch_taken = 1'b1;
        e = e_mcstall(1'b0); e.l1_pc_write = 1'b1;
        push(e, "mc_busy2_branch_ignored");
        next_cycle(); hif.ex_branch_taken = 1'b0;
        e = e_idle(); e.mc_done = 1'b1; e.l1_mc_done = 1'b1;
        push(e, "mc_done");
        next_cycle(); idle_inputs();
        push(e_idle(), "mc_back_to_run");

        // Branch suppresses MC start
        next_cycle(); hif.ex_is_mc = 1'b1; hif.ex_branch_taken = 1'b1;
        push(e_flush(), "branch_over_mc");
        next_cycle(); idle_inputs();
        push(e_idle(), "no_mc_after_branch");

        // Reset during MC_BUSY
        next_cycle(); hif.ex_is_mc = 1'b1;
        e = e_mcstall(1'b1); e.l1_pc_write = 1'b1; e.mc_start = 1'b1;
        push(e, "rst_mc_start");
        next_cycle();
        e = e_mcstall(1'b1); e.l1_pc_write = 1'b1;
        push(e, "rst_mc_busy1");
        next_cycle(); rst = 1'b0; hif.ex_is_mc = 1'b0;
        e = e_idle(); e.in_rst = 1'b1;
        push(e, "rst_mid_mc");
        next_cycle(); rst = 1'b1; hif.ex_is_mc = 1'b1; hif.ex_branch_taken = 1'b1;
        push(e_flush(), "run_after_rst");

        // Five consecutive stall cycles (counter saturation when enabled)
        for (int i = 0; i < 5; i++) begin
            next_cycle(); idle_inputs();
            hif.ex_memread = 1'b1; hif.ex_rd = 5'd20; hif.id_rs1 = 5'd20; hif.id_use_rs1 = 1'b1;
            push(e_loaduse(), "stall_run");
        end
        next_cycle(); idle_inputs();
        push(e_idle(), "final_idle");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            next_cycle();
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
